pe_spad_fifo: RTL and testbench

- Per-PE input scratchpad FIFO sitting directly downstream of the PE's multicast tag-match controller.
- Captures the forwarded 16-bit value on every cycle the controller asserts its enable, buffers it in order, and presents it to the PE MAC datapath with a pop interface.
- The multicast bus has no per-PE backpressure, so the block also raises an early stall request to the global bus scheduler and flags any dropped word.

---
 rtl/pe_spad_fifo.sv | 133 +++++++++++++
 tb/tb_pe_spad_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_spad_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pe_spad_fifo
//  Purpose  : Per-PE input scratchpad FIFO fed by the multicast tag-match
//             controller. Buffers forwarded values in order and presents them
//             first-word-fall-through to the PE MAC datapath. Because the
//             multicast bus cannot be back-pressured per PE, the block raises
//             an early stall request and records dropped pushes.
//  Ports    : clk, rst          - single clock, synchronous active-high reset
//             wr_en, wr_data    - push strobe / value (tag-match enable/value)
//             rd_en             - pop strobe from the PE datapath
//             rd_data, rd_valid - head entry (0 while empty) / non-empty flag
//             count             - occupancy 0..DEPTH
//             stall             - hold request to the bus scheduler
//             overflow          - sticky dropped-push flag
//             overflow_clr      - clears overflow (and drop_cnt when present)
//             drop_cnt          - saturating 8-bit drop counter, present only
//                                 when PE_SPAD_FIFO_STATS_EN is defined
//  Revision : 1.0 - initial release
// ============================================================================
module pe_spad_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int AFULL_FREE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       stall,
  output logic                       overflow,
  input  logic                       overflow_clr
`ifdef PE_SPAD_FIFO_STATS_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] c_depth      = CW'(DEPTH);
  localparam logic [CW-1:0] c_afull_free = CW'(AFULL_FREE);
  localparam logic [CW-1:0] c_cnt_one    = CW'(1);
  localparam logic [AW-1:0] c_ptr_one    = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  // A pop while empty is ignored, so an empty push+pop is a plain push.
  assign w_pop   = rd_en && !w_empty;
  // When full, a simultaneous pop frees the slot the new word lands in.
  assign w_push  = wr_en && (!w_full || w_pop);
  assign w_drop  = wr_en && w_full && !w_pop;

  // Storage has no reset: contents are only observable through r_count.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef PE_SPAD_FIFO_STATS_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (overflow_clr) begin
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign rd_valid = !w_empty;
  assign rd_data  = w_empty ? '0 : r_mem[r_rptr];
  assign count    = r_count;
  assign overflow = r_overflow;
  // Early warning leaves AFULL_FREE slots of slack for the scheduler pipeline.
  assign stall    = ((c_depth - r_count) <= c_afull_free);

endmodule
`default_nettype wire

// File: tb/tb_pe_spad_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_spad_fifo
//  Purpose  : Self-checking bench for pe_spad_fifo (DEPTH=8, AFULL_FREE=2)
//             using a queue scoreboard of expected head values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_spad_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AFREE  = 2;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [3:0]        count;
  logic              stall;
  logic              overflow;
  logic              overflow_clr;
`ifdef PE_SPAD_FIFO_STATS_EN
  logic [7:0]        drop_cnt;
`endif

  int checks;
  int failures;

  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf;
  int                m_drop;

  pe_spad_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_FREE(AFREE)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .stall        (stall),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef PE_SPAD_FIFO_STATS_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with scoreboard bookkeeping. Entered and left #1 after
  // a rising edge; outputs are sampled there.
  task automatic drive(input logic we, input logic [DATA_W-1:0] wd,
                       input logic re, input logic clr, input string tag);
    logic m_pop;
    logic m_push;
    logic m_dr;
    logic [DATA_W-1:0] e;
    int n;
    m_pop  = re && (exp_q.size() > 0);
    m_push = we && ((exp_q.size() < DEPTH) || m_pop);
    m_dr   = we && !m_push;
    wr_en = we; wr_data = wd; rd_en = re; overflow_clr = clr;
    if (m_pop) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e || rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s pop_data: got %h valid %b, expected %h valid 1",
                 tag, rd_data, rd_valid, e);
      end
    end
    if (m_push) exp_q.push_back(wd);
    if (m_dr) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_drop = m_dr ? 1 : 0;
    else if (m_dr && m_drop < 255) m_drop++;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; overflow_clr = 1'b0;
    n = exp_q.size();
    checks++;
    if (count !== 4'(n) || rd_valid !== (n > 0) || overflow !== m_ovf ||
        stall !== ((DEPTH - n) <= AFREE)) begin
      failures++;
      $display("FAIL %s status: got count=%0d valid=%b ovf=%b stall=%b, expected count=%0d valid=%b ovf=%b stall=%b",
               tag, count, rd_valid, overflow, stall, n, (n > 0), m_ovf,
               ((DEPTH - n) <= AFREE));
    end
    if (n == 0) begin
      checks++;
      if (rd_data !== '0) begin
        failures++;
        $display("FAIL %s empty_data: got %h, expected 0", tag, rd_data);
      end
    end
`ifdef PE_SPAD_FIFO_STATS_EN
    checks++;
    if (drop_cnt !== 8'(m_drop)) begin
      failures++;
      $display("FAIL %s drop_cnt: got %0d, expected %0d", tag, drop_cnt, m_drop);
    end
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); m_ovf = 1'b0; m_drop = 0;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) drive(1'b1, DATA_W'(base + i), 1'b0, 1'b0, "fill");
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) drive(1'b0, '0, 1'b1, 1'b0, tag);
  endtask

  task automatic test_reset;
    do_reset(2);
    checks++;
    if (count !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 16'h0 ||
        stall !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got count=%0d valid=%b data=%h stall=%b ovf=%b, expected all 0",
               count, rd_valid, rd_data, stall, overflow);
    end
    drive(1'b0, '0, 1'b1, 1'b0, "idle_pop_empty");
  endtask

  task automatic test_fill_drain;
    fill(8, 1);
    checks++;
    if (count !== 4'd8 || stall !== 1'b1) begin
      failures++;
      $display("FAIL fill_full: got count=%0d stall=%b, expected 8 1", count, stall);
    end
    drain("drain");
  endtask

  task automatic test_overflow;
    fill(8, 1);
    drive(1'b1, 16'hDEAD, 1'b0, 1'b0, "ovf_push");
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL ovf_set: got ovf=%b count=%0d, expected 1 8", overflow, count);
    end
    drain("ovf_drain");
    drive(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b, expected 0", overflow);
    end
    // Drop coinciding with a clear: set wins.
    fill(8, 16'h40);
    drive(1'b1, 16'hBEEF, 1'b0, 1'b1, "ovf_clr_and_drop");
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0, "ovf_second_drop");
    drive(1'b0, '0, 1'b0, 1'b1, "ovf_clr2");
    drain("ovf_drain2");
  endtask

  task automatic test_full_push_pop;
    fill(8, 1);
    drive(1'b1, 16'h0009, 1'b1, 1'b0, "full_push_pop");
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || rd_data !== 16'h0002) begin
      failures++;
      $display("FAIL full_pp: got count=%0d ovf=%b head=%h, expected 8 0 0002",
               count, overflow, rd_data);
    end
    drain("full_pp_drain");
  endtask

  task automatic test_empty_push_pop;
    drive(1'b1, 16'h00AA, 1'b1, 1'b0, "empty_push_pop");
    checks++;
    if (count !== 4'd1 || rd_valid !== 1'b1 || rd_data !== 16'h00AA) begin
      failures++;
      $display("FAIL empty_pp: got count=%0d valid=%b data=%h, expected 1 1 00aa",
               count, rd_valid, rd_data);
    end
    drain("empty_pp_drain");
  endtask

  task automatic test_reset_mid;
    fill(5, 16'h70);
    wr_en = 1'b1; wr_data = 16'h5555;
    do_reset(1);
    wr_en = 1'b0;
    checks++;
    if (count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || rd_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid: got count=%0d valid=%b ovf=%b data=%h, expected 0 0 0 0",
               count, rd_valid, overflow, rd_data);
    end
    drive(1'b0, '0, 1'b0, 1'b0, "reset_mid_idle");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 99) < 60), DATA_W'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5), "random");
    end
    drain("random_drain");
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; overflow_clr = 1'b0;
    m_ovf = 1'b0; m_drop = 0;
    @(posedge clk); #1;
    test_reset;
    test_fill_drain;
    test_overflow;
    test_full_push_pop;
    test_empty_push_pop;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
